matrix_result_reader: RTL
=========================

# matrix_result_reader

Streams a completed Z result matrix out of the Z RAM that `matrix_multiplier` writes. It is the read side of that Z RAM port. On `start` it walks the Z addresses row-major, in the same linear order the multiplier writes them. It issues synchronous RAM reads with one-cycle latency and delivers each element on a valid/ready output stream, using a small skid FIFO so it can run at full throughput under backpressure.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of the Z RAM address.
- `DATA_WIDTH`, 32: width of the Z RAM data and the stream data.
- `Z_ROWS`, 5: rows in Z (equals the multiplier's X_ROWS).
- `Z_COLS`, 5: columns in Z (equals the multiplier's Y_COLS).
- `Z_BASE_ADDR`, 0: address of element Z[0][0].

Ports:
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rst`, input, 1: reset. Asynchronous, active-high.
- `start`, input, 1: begin a readout. Sampled only in IDLE.
- `z_raddr`, output, ADDR_WIDTH: Z RAM read address. Registered.
- `z_ren`, output, 1: Z RAM read enable.
- `z_rdata`, input, DATA_WIDTH: Z RAM read data. Valid exactly 1 cycle after `z_ren`.
- `m_data`, output, DATA_WIDTH: stream data.
- `m_valid`, output, 1: stream valid.
- `m_ready`, input, 1: stream ready.
- `m_last`, output, 1: marks the final element, index Z_ROWS*Z_COLS-1.
- `busy`, output, 1: high from start acceptance until the last element is accepted.
- `done`, output, 1: single-cycle pulse after the last handshake.

## Operation
- Reset values of all outputs are 0. On reset the FIFO is empty and the in-flight flag and counters are cleared.
- The FSM has three states.
  - IDLE: when `start`=1, reset the read index, set `busy`, and go to READ.
  - READ: issue one read per cycle while credit allows. After issuing index N-1 (N = Z_ROWS*Z_COLS), go to DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight. Then go to IDLE and pulse `done` for 1 cycle.
- Read issue rules:
  - `z_ren`=1 in a cycle only if (fifo_count + inflight − pop) < 2, where pop = `m_valid` & `m_ready`.
  - `z_raddr` = Z_BASE_ADDR + index. Index increments by 1 per issued read and wraps modulo 2^ADDR_WIDTH.
- FIFO is 2 entries deep.
  - Writes occur on the cycle after `z_ren`. The in-flight data is captured unconditionally; the credit rule guarantees space.
  - The FIFO head drives `m_data`/`m_valid`/`m_last`.
- Stream rules:
  - While `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` are held stable.
  - A push and a pop in the same cycle are both honoured.
- `start` while busy is ignored. `start` held high in IDLE after `done` begins a new readout.
- If Z_ROWS*Z_COLS = 1, the single element carries `m_last`=1.
- An `rst` assertion mid-readout aborts the readout immediately. The in-flight read data is discarded and no `done` pulse is issued.

## Timing
- `start` is sampled at edge E0.
  - `z_ren`=1 with `z_raddr`=Z_BASE_ADDR in cycle E0–E1.
  - Data is captured at E2; `m_valid`=1 from E2.
- With `m_ready` held at 1: one element per cycle, and the readout of N elements takes N+2 cycles to the last handshake.
- `done` is high for the cycle immediately after the last handshake edge. `busy` falls at that same edge.
- Backpressure: reads stall within 1 cycle of `m_ready`=0. At most 2 elements are buffered, and nothing is lost or duplicated.

## Configuration
- Macro: `RESULT_READER_ROW_END_EN`.
- When defined, the block adds output `m_row_end` (1 bit, reset 0). It is high alongside `m_valid` on every element whose column index equals Z_COLS-1, travels through the FIFO with its data, and is held under backpressure.
- When undefined, the port and its logic are absent. Only `m_last` marks a boundary.

## Test plan
- 5x5 readout, with RAM preloaded Z[i] = 100+i and `m_ready`=1:
  - 25 beats with data 100..124 in order.
  - `m_last` only on 124.
  - `done` pulses once, 27 cycles after `start`.
- Backpressure, with `m_ready` toggling 1,0,0,1 repeatedly:
  - The data sequence is identical to the first test.
  - `m_data` is stable during stalls.
  - `z_ren` never issues with 2 entries occupied and none leaving.
- `start` re-asserted at beat 10: ignored; exactly 25 beats are delivered.
- `rst` pulsed at beat 7:
  - All outputs are 0 the same cycle.
  - No `done` pulse.
  - A subsequent `start` restarts at Z_BASE_ADDR with data 100.
- Z_BASE_ADDR=0x40, Z_ROWS=2, Z_COLS=3, macro defined:
  - Addresses 0x40..0x45.
  - `m_row_end` on beats 2 and 5.
  - `m_last` on beat 5.
- Z_ROWS=Z_COLS=1: one beat with `m_last`=1, then `done`.

Source files
------------

// File: rtl/matrix_result_reader.sv
// matrix_result_reader: streams a finished Z matrix out of the Z RAM read port,
// row-major, onto a valid/ready stream through a 2-entry skid FIFO.
// Optional feature macro: RESULT_READER_ROW_END_EN (adds m_row_end, marks last column).
module matrix_result_reader #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           Z_ROWS      = 5,
  parameter int unsigned           Z_COLS      = 5,
  parameter logic [ADDR_WIDTH-1:0] Z_BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] z_raddr,
  output logic                  z_ren,
  input  logic [DATA_WIDTH-1:0] z_rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
`ifdef RESULT_READER_ROW_END_EN
  output logic                  m_row_end,
`endif
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned N        = Z_ROWS * Z_COLS;
  localparam int unsigned CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    busy_next;
  logic                    done_next;

  logic [CNT_W-1:0]        issue_cnt;
  logic                    issue_last;
  logic                    inflight;
  logic                    inflight_last;

  logic [DATA_WIDTH-1:0]   fifo_data [2];
  logic                    fifo_last [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              fifo_count;

  logic                    push;
  logic                    pop;
  logic [2:0]              occ;
  logic                    start_accept;

`ifdef RESULT_READER_ROW_END_EN
  localparam int unsigned COL_W = (Z_COLS > 1) ? $clog2(Z_COLS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(Z_COLS - 1);

  logic [COL_W-1:0]        col_cnt;
  logic                    issue_row_end;
  logic                    inflight_row_end;
  logic                    fifo_row_end [2];
`endif

  // Handshake, occupancy and read-issue credit
  always_comb begin
    push         = inflight;
    pop          = m_valid & m_ready;
    occ          = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    issue_last   = (issue_cnt == LAST_IDX);
    start_accept = (state == S_IDLE) && start;
    z_ren        = (state == S_READ) && (occ < 3'd2);
  end

  // Stream head of the FIFO
  always_comb begin
    m_valid = (fifo_count != 2'd0);
    m_data  = fifo_data[rd_ptr];
    m_last  = m_valid & fifo_last[rd_ptr];
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state; done fires on the final handshake since that empties everything
  always_comb begin
    state_next = state;
    busy_next  = busy;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_READ;
          busy_next  = 1'b1;
        end
      end
      S_READ: begin
        if (z_ren && issue_last) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && m_last) begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
    end
  end

  // Read address generation and in-flight tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_raddr       <= '0;
      issue_cnt     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= z_ren;
      inflight_last <= z_ren & issue_last;
      if (start_accept) begin
        z_raddr   <= Z_BASE_ADDR;
        issue_cnt <= '0;
      end else if (z_ren) begin
        z_raddr   <= z_raddr + ADDR_WIDTH'(1);
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
    end
  end

  // Two-entry FIFO; the credit rule guarantees a free slot whenever data lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= z_rdata;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef RESULT_READER_ROW_END_EN
  // Column tracking for the row-end marker
  always_comb begin
    issue_row_end = (col_cnt == LAST_COL);
    m_row_end     = m_valid & fifo_row_end[rd_ptr];
  end

  // Row-end flag follows its element through the read pipe and FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt          <= '0;
      inflight_row_end <= 1'b0;
      fifo_row_end[0]  <= 1'b0;
      fifo_row_end[1]  <= 1'b0;
    end else begin
      inflight_row_end <= z_ren & issue_row_end;
      if (start_accept) begin
        col_cnt <= '0;
      end else if (z_ren) begin
        col_cnt <= issue_row_end ? '0 : col_cnt + COL_W'(1);
      end
      if (push) begin
        fifo_row_end[wr_ptr] <= inflight_row_end;
      end
    end
  end
`endif

endmodule
